// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared scan-FSM state type, code width and column helpers
// for the keypad scanner and its code queue.
package keypad_scan_ctrl_pkg;

  localparam int         CODE_W   = 4;
  localparam logic [3:0] ALL_COLS = 4'b1111;

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, SCAN0, SCAN1, SCAN2, SCAN3, PUSH, RELEASE
  } scanState_t;

  // One column is driven per scan step; every other state drives all columns.
  function automatic logic [3:0] colDrive(input scanState_t s);
    case (s)
      SCAN0:   colDrive = 4'b0001;
      SCAN1:   colDrive = 4'b0010;
      SCAN2:   colDrive = 4'b0100;
      SCAN3:   colDrive = 4'b1000;
      default: colDrive = ALL_COLS;
    endcase
  endfunction

  function automatic logic [1:0] scanIndex(input scanState_t s);
    case (s)
      SCAN1:   scanIndex = 2'd1;
      SCAN2:   scanIndex = 2'd2;
      SCAN3:   scanIndex = 2'd3;
      default: scanIndex = 2'd0;
    endcase
  endfunction

  // An empty final column means the key vanished mid-scan: give up quietly.
  function automatic scanState_t nextScan(input scanState_t s);
    case (s)
      SCAN0:   nextScan = SCAN1;
      SCAN1:   nextScan = SCAN2;
      SCAN2:   nextScan = SCAN3;
      default: nextScan = IDLE;
    endcase
  endfunction

  function automatic logic [1:0] lowestRow(input logic [3:0] r);
    if (r[0])      lowestRow = 2'd0;
    else if (r[1]) lowestRow = 2'd1;
    else if (r[2]) lowestRow = 2'd2;
    else           lowestRow = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Key-code queue: power-of-two FIFO with sticky overflow on dropped writes.
module keypad_code_fifo
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [CODE_W-1:0] wr_data_i,
  input  logic              rd_ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] data_o,
  output logic              overflow_o
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [PTR_W:0]    count_q;
  logic              overflow_q;
  logic              empty, full, pop, push;

  // A pop needs a head to pop, so write+pop on an empty queue only writes;
  // a full queue accepts a write only when the head leaves in the same cycle.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign pop   = !empty && rd_ready_i;
  assign push  = wr_en_i && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= wr_data_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W + 1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W + 1)'(1);
      if (wr_en_i && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign valid_o    = !empty;
  assign data_o     = mem_q[rdPtr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: debounces a press, walks the columns to locate the key,
// queues one code per press and waits for a debounced release.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              overflow
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  scanState_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cntInc;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        col_q;
  logic              pushEn;

  assign cntInc = cnt_q + CNT_W'(1);

  // Column drive is registered from the next state so it lines up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      col_q   <= ALL_COLS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      col_q   <= colDrive(state_d);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (row != 4'b0) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (row == 4'b0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cntInc == CNT_TARGET) begin
          cnt_d   = '0;
          state_d = SCAN0;
        end else begin
          cnt_d = cntInc;
        end
      end
      SCAN0, SCAN1, SCAN2, SCAN3: begin
        if (row != 4'b0) begin
          code_d  = {lowestRow(row), scanIndex(state_q)};
          state_d = PUSH;
        end else begin
          state_d = nextScan(state_q);
        end
      end
      PUSH: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Any bounce back to a pressed row restarts the release count.
        if (row != 4'b0) begin
          cnt_d = '0;
        end else if (cntInc == CNT_TARGET) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cntInc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pushEn = (state_q == PUSH);
  assign col    = col_q;

  keypad_code_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (pushEn),
    .wr_data_i (code_q),
    .rd_ready_i(key_ready),
    .valid_o   (key_valid),
    .data_o    (key_code),
    .overflow_o(overflow)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: an ideal switch-matrix keypad model
// drives the rows, expected codes are queued at press time and popped by a monitor.
module tb_keypad_scan_ctrl;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int FIFO_DEPTH      = 4;

  logic        clk, reset, key_ready, key_valid, overflow;
  logic [3:0]  row, col, key_code;
  logic [15:0] keyMask;

  int          checks, errors, popCount, p0;
  logic [3:0]  expQ[$];
  logic [3:0]  colLog[$];
  bit          expOverflow, randReady, pushSeen, found;
  logic        vAtPush, vAfterPush;

  keypad_scan_ctrl #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ideal keypad: a row line is high when a pressed key joins it to a driven column.
  always_comb begin
    row = 4'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (keyMask[4*i+j] && col[j]) row[i] = 1'b1;
  end

  // The reported key is the first driven column holding a press, lowest row within it.
  function automatic logic [3:0] refCode(input logic [15:0] keys);
    refCode = 4'h0;
    for (int j = 3; j >= 0; j--)
      for (int i = 3; i >= 0; i--)
        if (keys[4*i+j]) refCode = 4'(4*i + j);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (randReady) key_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic logCol();
    if (colLog.size() == 0 || colLog[$] != col) colLog.push_back(col);
  endtask

  // Holds a key pattern, optionally pulsing key_ready only during the queue-write cycle.
  task automatic applyStimulus(input logic [15:0] keys, input int holdCycles, input bit pulseReady);
    int stage;
    stage      = 0;
    pushSeen   = 1'b0;
    vAtPush    = 1'b0;
    vAfterPush = 1'b0;
    if (expQ.size() < FIFO_DEPTH || pulseReady) expQ.push_back(refCode(keys));
    else expOverflow = 1'b1;
    keyMask = keys;
    logCol();
    for (int c = 0; c < holdCycles; c++) begin
      tick();
      logCol();
      if (stage == 1) begin
        vAtPush = key_valid;
        if (pulseReady) key_ready = 1'b1;
        stage = 2;
      end else if (stage == 2) begin
        vAfterPush = key_valid;
        if (pulseReady) key_ready = 1'b0;
        stage = 3;
      end else if (stage == 0 && col != 4'hF && row != 4'b0) begin
        pushSeen = 1'b1;
        stage    = 1;
      end
    end
    keyMask = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      logCol();
    end
  endtask

  task automatic applyGlitch(input logic [15:0] keys, input int len);
    bit sawScan, sawValid, checkValid;
    sawScan    = 1'b0;
    sawValid   = 1'b0;
    checkValid = (expQ.size() == 0);
    keyMask    = keys;
    for (int c = 0; c < len + 8; c++) begin
      if (c == len) keyMask = '0;
      tick();
      if (col != 4'hF) sawScan = 1'b1;
      if (key_valid) sawValid = 1'b1;
    end
    checkOutput("glitch_no_scan", int'(sawScan), 0);
    if (checkValid) checkOutput("glitch_no_valid", int'(sawValid), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    expQ.delete();
    expOverflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Monitor: every accepted head must match the oldest expected code.
  initial begin
    bit         stall;
    logic [3:0] heldCode;
    logic [3:0] expCode;
    stall    = 1'b0;
    heldCode = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall && key_valid) checkOutput("code_hold", int'(key_code), int'(heldCode));
        if (key_valid && key_ready) begin
          checkOutput("pop_expected", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            expCode = expQ.pop_front();
            checkOutput("pop_code", int'(key_code), int'(expCode));
          end
          popCount++;
        end
        stall    = key_valid && !key_ready;
        heldCode = key_code;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; popCount = 0;
    keyMask = '0; key_ready = 1'b0; reset = 1'b1;
    randReady = 1'b0; expOverflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("reset_col", int'(col), 15);
    checkOutput("reset_valid", int'(key_valid), 0);
    checkOutput("reset_code", int'(key_code), 0);
    checkOutput("reset_overflow", int'(overflow), 0);

    $display("[TB] single key row 2 col 1 held");
    key_ready = 1'b1;
    p0 = popCount;
    colLog.delete();
    applyStimulus(16'h0200, 20, 1'b0);
    checkOutput("col_walk_len", int'(colLog.size() >= 3), 1);
    if (colLog.size() >= 3) begin
      checkOutput("col_walk0", int'(colLog[0]), 15);
      checkOutput("col_walk1", int'(colLog[1]), 1);
      checkOutput("col_walk2", int'(colLog[2]), 2);
    end
    checkOutput("push_seen", int'(pushSeen), 1);
    checkOutput("latency_at_push", int'(vAtPush), 0);
    checkOutput("latency_after_push", int'(vAfterPush), 1);
    checkOutput("single_code_count", popCount - p0, 1);
    checkOutput("single_code_drained", expQ.size(), 0);

    $display("[TB] two-cycle glitch");
    applyGlitch(16'h0020, 2);

    $display("[TB] rows 1 and 3 on col 3");
    p0 = popCount;
    applyStimulus(16'h8080, 20, 1'b0);
    checkOutput("multi_row_count", popCount - p0, 1);
    checkOutput("multi_row_drained", expQ.size(), 0);

    $display("[TB] five presses with consumer stalled");
    key_ready = 1'b0;
    applyStimulus(16'h0001, 18, 1'b0);
    applyStimulus(16'h0020, 18, 1'b0);
    applyStimulus(16'h0400, 18, 1'b0);
    applyStimulus(16'h8000, 18, 1'b0);
    checkOutput("full_no_overflow", int'(overflow), 0);
    checkOutput("full_valid", int'(key_valid), 1);
    applyStimulus(16'h0008, 18, 1'b0);
    checkOutput("overflow_set", int'(overflow), int'(expOverflow));
    checkOutput("overflow_head", int'(key_code), 0);
    checkOutput("overflow_depth", expQ.size(), FIFO_DEPTH);
    p0 = popCount;
    key_ready = 1'b1;
    repeat (8) tick();
    key_ready = 1'b0;
    checkOutput("drain_count", popCount - p0, 4);
    checkOutput("drain_empty", int'(key_valid), 0);
    checkOutput("overflow_sticky", int'(overflow), 1);

    $display("[TB] full queue with pop during write");
    doReset();
    checkOutput("reset_clears_overflow", int'(overflow), 0);
    applyStimulus(16'h0002, 18, 1'b0);
    applyStimulus(16'h0004, 18, 1'b0);
    applyStimulus(16'h0010, 18, 1'b0);
    applyStimulus(16'h0100, 18, 1'b0);
    applyStimulus(16'h0040, 20, 1'b1);
    checkOutput("simul_push_seen", int'(pushSeen), 1);
    checkOutput("simul_no_overflow", int'(overflow), 0);
    checkOutput("simul_depth", expQ.size(), FIFO_DEPTH);
    p0 = popCount;
    key_ready = 1'b1;
    repeat (8) tick();
    checkOutput("simul_drain_count", popCount - p0, 4);
    checkOutput("simul_drained", expQ.size(), 0);

    $display("[TB] reset during column 2 scan");
    keyMask = 16'h0004;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (col == 4'b0100) found = 1'b1;
    end
    checkOutput("reached_scan2", int'(found), 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_col", int'(col), 15);
    checkOutput("abort_valid", int'(key_valid), 0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    expQ.push_back(refCode(keyMask));
    p0 = popCount;
    repeat (15) tick();
    keyMask = '0;
    repeat (10) tick();
    checkOutput("repress_count", popCount - p0, 1);
    checkOutput("repress_drained", expQ.size(), 0);

    $display("[TB] randomized presses and glitches");
    randReady = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [15:0] m;
      m = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) m = m | (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) applyGlitch(m, $urandom_range(1, 3));
      else applyStimulus(m, $urandom_range(12, 20), 1'b0);
    end
    randReady = 1'b0;
    key_ready = 1'b1;
    repeat (10) tick();
    checkOutput("random_drained", expQ.size(), 0);
    checkOutput("random_no_overflow", int'(overflow), int'(expOverflow));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required for press and release.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 4: key-code queue entries, a power of two, at least 2.
REQ-003 Port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port row, input, 4 bits: keypad row lines, already synchronized to clk externally; bit i is row i.
REQ-006 Port col, output, 4 bits: registered column drive; bit j drives column j.
REQ-007 Port key_valid, output, 1 bit: the queue head holds a code.
REQ-008 Port key_code, output, 4 bits: queue head code, equal to 4*row_index + col_index.
REQ-009 Port key_ready, input, 1 bit: the consumer accepts the head when high together with key_valid.
REQ-010 Port overflow, output, 1 bit: sticky flag, set when a code was dropped because the queue was full.

Function
REQ-011 The scan FSM SHALL have the states IDLE, DEBOUNCE, SCAN0, SCAN1, SCAN2, SCAN3, PUSH and RELEASE.
REQ-012 The col output SHALL be 4'b1111 in IDLE, DEBOUNCE, PUSH and RELEASE, and 4'b0001 << j in state SCANj.
REQ-013 IDLE SHALL go to DEBOUNCE when row != 0, and SHALL clear the stability counter.
REQ-014 DEBOUNCE SHALL count consecutive cycles with row != 0.
  - If row == 0: return to IDLE.
  - When the count reaches DEBOUNCE_CYCLES: go to SCAN0.
REQ-015 SCANj SHALL act on row as follows:
  - row != 0: latch code = 4*i + j, where i is the lowest set row bit, then go to PUSH.
  - row == 0, j < 3: go to SCAN(j+1).
  - row == 0 in SCAN3: go to IDLE; no code is produced.
REQ-016 PUSH SHALL last exactly one cycle, SHALL issue one queue write of the latched code, and SHALL then go to RELEASE.
REQ-017 RELEASE SHALL count consecutive cycles with row == 0, reset the count on any row != 0, and go to IDLE when the count reaches DEBOUNCE_CYCLES.
REQ-018 Each debounced press SHALL produce exactly one code; holding a key SHALL NOT produce further codes.
REQ-019 The queue SHALL be a FIFO of FIFO_DEPTH entries of 4 bits, with key_valid = not empty and key_code = head entry.
REQ-020 A pop SHALL occur when key_valid && key_ready; key_code SHALL hold steady while key_valid && !key_ready.
REQ-021 A write to a full queue with no pop in the same cycle SHALL drop the code, leave the queue unchanged, and set overflow.
REQ-022 A write to a full queue with a simultaneous pop SHALL be accepted, and the occupancy SHALL stay at FIFO_DEPTH.
REQ-023 A simultaneous write and pop on an empty queue SHALL NOT pop; the written code SHALL appear at the head on the next cycle.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-025 Latency SHALL be 1 cycle from the PUSH edge to key_valid rising on an empty queue.

Reset
REQ-026 Reset SHALL set the following:
  - FSM to IDLE, col = 4'b1111.
  - Queue empty, so key_valid = 0.
  - key_code = 0, overflow = 0, all counters 0.
REQ-027 Reset asserted mid-scan or mid-release SHALL abort the operation and discard any latched, unqueued code.
REQ-028 A key still held when reset is released SHALL be treated as a new press after DEBOUNCE_CYCLES.
REQ-029 Reset SHALL be the only means of clearing overflow.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the code width constant (4) and the all-columns constant (4'b1111).
REQ-031 The queue SHALL be a single sub-module, keypad_code_fifo, parameterized by FIFO_DEPTH; the FSM and counters SHALL stay in keypad_scan_ctrl.

Verification
REQ-032 Key at row 2, col 1, held 20 cycles, key_ready = 1 -> col walks 1111, 0001, 0010; exactly one code 9 is output; no repeat while held.
REQ-033 Row glitch lasting 2 cycles with DEBOUNCE_CYCLES = 4 -> FSM returns to IDLE; key_valid stays 0.
REQ-034 Rows 1 and 3 active at col 3 -> code 7 (lowest row wins).
REQ-035 Five presses (codes 0, 5, 10, 15, 3) with key_ready = 0 -> four entries queued, overflow = 1; after draining, codes 0, 5, 10, 15 appear in order.
REQ-036 Queue full, press completes while key_ready = 1 in the PUSH cycle -> no overflow; occupancy stays 4.
REQ-037 Reset during SCAN2 with a key held -> col = 1111 and key_valid = 0 immediately; one code is produced after re-debounce.
